// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes, instruction opcodes, B-bus
// source encodings and the control sequencer state encoding.
package cpu_pkg;

    localparam logic [3:0] ALU_NONE     = 4'd0;
    localparam logic [3:0] ALU_ADD      = 4'd1;
    localparam logic [3:0] ALU_SUB      = 4'd2;
    localparam logic [3:0] ALU_LSHFT1   = 4'd3;
    localparam logic [3:0] ALU_RSHFT4   = 4'd6;
    localparam logic [3:0] ALU_PASSATOC = 4'd7;
    localparam logic [3:0] ALU_PASSBTOC = 4'd8;
    localparam logic [3:0] ALU_INCAC    = 4'd9;
    localparam logic [3:0] ALU_DECAC    = 4'd10;
    localparam logic [3:0] ALU_RESET    = 4'd11;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_LDAC   = 4'd1;
    localparam logic [3:0] OP_STAC   = 4'd2;
    localparam logic [3:0] OP_ADD    = 4'd3;
    localparam logic [3:0] OP_SUB    = 4'd4;
    localparam logic [3:0] OP_MVACR  = 4'd5;
    localparam logic [3:0] OP_MVRAC  = 4'd6;
    localparam logic [3:0] OP_JUMP   = 4'd7;
    localparam logic [3:0] OP_JMPZ   = 4'd8;
    localparam logic [3:0] OP_JMPNZ  = 4'd9;
    localparam logic [3:0] OP_INAC   = 4'd10;
    localparam logic [3:0] OP_DEAC   = 4'd11;
    localparam logic [3:0] OP_LSHFT1 = 4'd12;
    localparam logic [3:0] OP_RSHFT4 = 4'd13;
    localparam logic [3:0] OP_CLAC   = 4'd14;
    localparam logic [3:0] OP_HALT   = 4'd15;

    localparam logic [1:0] BSEL_R    = 2'd0;
    localparam logic [1:0] BSEL_MEM  = 2'd1;
    localparam logic [1:0] BSEL_IR   = 2'd2;
    localparam logic [1:0] BSEL_PC   = 2'd3;

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/ctrl_sequencer.sv
// Control FSM upstream of the 24-bit ALU: fetch/decode/execute sequencing,
// combinational strobe decode and the architectural zero flag.
module ctrl_sequencer
    import cpu_pkg::*;
#(
    parameter int OPC_W    = 4,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [OPC_W-1:0]    opcode,
    input  logic                alu_z,
    input  logic                mem_ready,
    output logic [ALU_OP_W-1:0] alu_oper,
    output logic [1:0]          b_sel,
    output logic                addr_sel,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                ld_ir,
    output logic                ld_ac,
    output logic                ld_r,
    output logic                ld_pc,
    output logic                inc_pc,
    output logic                z_q,
    output logic                halted
);

    state_t state_q, state_d;
    logic   z_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_START;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        z_d      = z_q;
        alu_oper = ALU_OP_W'(ALU_NONE);
        b_sel    = BSEL_R;
        addr_sel = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        ld_ir    = 1'b0;
        ld_ac    = 1'b0;
        ld_r     = 1'b0;
        ld_pc    = 1'b0;
        inc_pc   = 1'b0;
        halted   = 1'b0;

        case (state_q)
            ST_START: if (run) state_d = ST_FETCH;

            ST_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ld_ir   = 1'b1;
                    inc_pc  = 1'b1;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: state_d = (opcode == OP_HALT) ? ST_HALT : ST_EXEC;

            ST_EXEC: begin
                state_d = ST_FETCH;
                case (opcode)
                    OP_LDAC, OP_STAC: state_d = ST_MEM;
                    OP_ADD:    begin alu_oper = ALU_OP_W'(ALU_ADD);      ld_ac = 1'b1; end
                    OP_SUB:    begin
                        alu_oper = ALU_OP_W'(ALU_SUB);
                        ld_ac    = 1'b1;
                        z_d      = alu_z;
                    end
                    OP_MVACR:  begin alu_oper = ALU_OP_W'(ALU_PASSATOC); ld_r  = 1'b1; end
                    OP_MVRAC:  begin alu_oper = ALU_OP_W'(ALU_PASSBTOC); ld_ac = 1'b1; end
                    OP_JUMP, OP_JMPZ, OP_JMPNZ: begin
                        // Conditional jumps collapse to JUMP when the flag test holds.
                        if (opcode == OP_JUMP || (opcode == OP_JMPZ && z_q) ||
                            (opcode == OP_JMPNZ && !z_q)) begin
                            alu_oper = ALU_OP_W'(ALU_PASSBTOC);
                            b_sel    = BSEL_IR;
                            ld_pc    = 1'b1;
                        end
                    end
                    OP_INAC:   begin alu_oper = ALU_OP_W'(ALU_INCAC);    ld_ac = 1'b1; end
                    OP_DEAC:   begin alu_oper = ALU_OP_W'(ALU_DECAC);    ld_ac = 1'b1; end
                    OP_LSHFT1: begin alu_oper = ALU_OP_W'(ALU_LSHFT1);   ld_ac = 1'b1; end
                    OP_RSHFT4: begin alu_oper = ALU_OP_W'(ALU_RSHFT4);   ld_ac = 1'b1; end
                    OP_CLAC:   begin alu_oper = ALU_OP_W'(ALU_RESET);    ld_ac = 1'b1; end
                    default: ;
                endcase
            end

            ST_MEM: begin
                addr_sel = 1'b1;
                if (opcode == OP_STAC) begin
                    mem_wr   = 1'b1;
                    alu_oper = ALU_OP_W'(ALU_PASSATOC);
                end else begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        alu_oper = ALU_OP_W'(ALU_PASSBTOC);
                        b_sel    = BSEL_MEM;
                        ld_ac    = 1'b1;
                    end
                end
                if (mem_ready) state_d = ST_FETCH;
            end

            ST_HALT: halted = 1'b1;

            default: state_d = ST_START;
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: directed per-cycle vectors queued by the
// stimulus process, compared by an independent negedge monitor.
module tb_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       alu_z = 1'b0;
    logic       mem_ready = 1'b0;
    logic [3:0] alu_oper;
    logic [1:0] b_sel;
    logic       addr_sel, mem_rd, mem_wr, ld_ir, ld_ac, ld_r, ld_pc, inc_pc, z_q, halted;

    ctrl_sequencer #(.OPC_W(4), .ALU_OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .alu_z(alu_z),
        .mem_ready(mem_ready), .alu_oper(alu_oper), .b_sel(b_sel), .addr_sel(addr_sel),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .ld_ir(ld_ir), .ld_ac(ld_ac), .ld_r(ld_r),
        .ld_pc(ld_pc), .inc_pc(inc_pc), .z_q(z_q), .halted(halted)
    );

    always #5 clk = ~clk;

    // Packed view of every output: [15:12] alu_oper, [11:10] b_sel, then single bits.
    logic [15:0] obs;
    assign obs = {alu_oper, b_sel, addr_sel, mem_rd, mem_wr, ld_ir, ld_ac, ld_r,
                  ld_pc, inc_pc, z_q, halted};

    localparam logic [15:0] ADR = 16'h0200, RD = 16'h0100, WR  = 16'h0080, IR  = 16'h0040;
    localparam logic [15:0] AC  = 16'h0020, R  = 16'h0010, PC  = 16'h0008, INC = 16'h0004;
    localparam logic [15:0] Z   = 16'h0002, HLT = 16'h0001;

    function automatic logic [15:0] A(input int n);
        return 16'(n) << 12;
    endfunction
    function automatic logic [15:0] B(input int n);
        return 16'(n) << 10;
    endfunction

    typedef struct {
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t expq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            n_chk++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL %s: outputs=%h required=%h at %0t", e.name, obs, e.exp, $time);
            end
        end
    end

    // One cycle: drive inputs just after the rising edge, queue the expected outputs.
    task automatic step(input logic rn, input logic r, input logic [3:0] op,
                        input logic mr, input logic az, input logic [15:0] e,
                        input string nm);
        exp_t it;
        @(posedge clk);
        #1;
        rst_n = rn; run = r; opcode = op; mem_ready = mr; alu_z = az;
        it.exp = e; it.name = nm;
        expq.push_back(it);
    endtask

    // Zero-wait fetch then decode; mem_ready stays high in DECODE, where it is ignored.
    task automatic fd(input logic [3:0] op, input logic [15:0] z);
        step(1, 0, op, 1, 0, RD | IR | INC | z, "fetch");
        step(1, 0, op, 1, 0, z, "decode");
    endtask

    initial begin
        // Reset with run held high, then one START cycle and a waiting FETCH.
        step(0, 1, 4'd0, 0, 0, 16'h0, "reset_outputs");
        step(1, 1, 4'd0, 0, 0, 16'h0, "start");
        step(1, 1, 4'd0, 0, 0, RD, "fetch_wait");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (mem_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_mem_rd: mem_rd=%b required=0", mem_rd);
        end
        step(0, 1, 4'd0, 0, 0, 16'h0, "reset_held");
        step(1, 1, 4'd0, 0, 0, 16'h0, "start2");

        // ADD, zero wait.
        fd(4'd3, 0);
        step(1, 0, 4'd3, 1, 0, A(1) | B(0) | AC, "exec_add");

        // SUB with alu_z=1, then JMPZ taken.
        fd(4'd4, 0);
        step(1, 0, 4'd4, 0, 1, A(2) | AC, "exec_sub_z1");
        fd(4'd8, Z);
        step(1, 0, 4'd8, 0, 0, A(8) | B(2) | PC | Z, "exec_jmpz_taken");

        // SUB with alu_z=0, JMPZ not taken, JMPNZ taken.
        fd(4'd4, Z);
        step(1, 0, 4'd4, 0, 0, A(2) | AC | Z, "exec_sub_z0");
        fd(4'd8, 0);
        step(1, 0, 4'd8, 0, 1, 16'h0, "exec_jmpz_nottaken");
        fd(4'd9, 0);
        step(1, 0, 4'd9, 0, 0, A(8) | B(2) | PC, "exec_jmpnz_taken");

        // Register moves and CLAC; MVACR fetch takes one wait cycle.
        step(1, 0, 4'd5, 0, 0, RD, "fetch_wait_mvacr");
        fd(4'd5, 0);
        step(1, 0, 4'd5, 0, 0, A(7) | R, "exec_mvacr");
        fd(4'd6, 0);
        step(1, 0, 4'd6, 0, 0, A(8) | B(0) | AC, "exec_mvrac");
        fd(4'd14, 0);
        step(1, 0, 4'd14, 0, 0, A(11) | AC, "exec_clac");

        // LDAC with 3 wait cycles.
        fd(4'd1, 0);
        step(1, 0, 4'd1, 1, 0, 16'h0, "exec_ldac");
        for (int i = 0; i < 3; i++) step(1, 0, 4'd1, 0, 0, ADR | RD, "mem_ldac_wait");
        step(1, 0, 4'd1, 1, 0, ADR | RD | A(8) | B(1) | AC, "mem_ldac_ready");
        step(1, 0, 4'd1, 0, 0, RD, "fetch_after_ldac");

        // STAC with 2 wait cycles (reuses the FETCH above).
        step(1, 0, 4'd2, 1, 0, RD | IR | INC, "fetch_stac");
        step(1, 0, 4'd2, 0, 0, 16'h0, "decode_stac");
        step(1, 0, 4'd2, 0, 0, 16'h0, "exec_stac");
        for (int i = 0; i < 2; i++) step(1, 0, 4'd2, 0, 0, ADR | WR | A(7), "mem_stac_wait");
        step(1, 0, 4'd2, 1, 0, ADR | WR | A(7), "mem_stac_ready");

        // Set z, then HALT with noisy run/mem_ready.
        fd(4'd4, 0);
        step(1, 0, 4'd4, 0, 1, A(2) | AC, "exec_sub_pre_halt");
        fd(4'd15, Z);
        for (int i = 0; i < 100; i++)
            step(1, 1'($urandom), 4'd15, 1'($urandom), 1'($urandom), HLT | Z, "halt");

        // Only reset leaves HALT; z_q clears with it.
        step(0, 1, 4'd15, 1, 0, 16'h0, "halt_reset");
        step(1, 0, 4'd0, 1, 0, 16'h0, "start_idle0");
        step(1, 0, 4'd0, 1, 0, 16'h0, "start_idle1");
        step(1, 1, 4'd0, 0, 0, 16'h0, "start_run");
        step(1, 0, 4'd0, 0, 0, RD, "fetch_after_restart");

        for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
        if (expq.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Microcoded-style control FSM sitting directly upstream of the 24-bit ALU.
- Fetches instructions, decodes the 4-bit opcode from the instruction register, and drives:
  - the ALU operation code;
  - the B-bus source select;
  - the register load strobes;
  - the memory read/write handshake.
- Holds the architectural zero flag, captured from the ALU Z output on SUB, which conditional jumps consume.

Parameters:
- OPC_W, 4, opcode field width (IR[23:20]).
- ALU_OP_W, 4, width of the ALU operation code.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  start enable; sampled in START.
- opcode  in  OPC_W  IR[23:20], stable from DECODE onwards.
- alu_z  in  1  ALU zero flag, valid in the SUB execute cycle.
- mem_ready  in  1  memory completion strobe.
- alu_oper  out  ALU_OP_W  operation code to the ALU.
- b_sel  out  2  B-bus source: 0=R, 1=MEM data, 2=IR address field, 3=PC.
- addr_sel  out  1  memory address source: 0=PC, 1=IR address field.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- ld_ir  out  1  IR load strobe.
- ld_ac  out  1  AC load strobe (from C bus).
- ld_r  out  1  R load strobe (from C bus).
- ld_pc  out  1  PC load strobe (from C bus).
- inc_pc  out  1  PC increment strobe.
- z_q  out  1  registered zero flag.
- halted  out  1  high while in HALT.

Behaviour:
- Reset: asynchronous and active-low. Every output, including z_q, is 0 immediately on rst_n low. The state is START.
- Reset mid-operation: a pending mem_rd/mem_wr drops the same instant. Reset has no other side effects.
- States: START, FETCH, DECODE, EXEC, MEM, HALT. Outputs decode combinationally from state, opcode and mem_ready. z_q and state are the only flops.
- START:
  - All outputs 0.
  - run=1 -> FETCH next cycle; otherwise stay.
- FETCH:
  - mem_rd=1, addr_sel=0.
  - mem_ready=0: stay; requests are held, with no timeout.
  - mem_ready=1: ld_ir=1 and inc_pc=1 in that same cycle -> DECODE.
- DECODE: all strobes 0; 1 cycle -> EXEC, except opcode HALT -> HALT.
- EXEC, per opcode; every case below -> FETCH unless it says MEM:
  - 0 NOP: no strobes.
  - 1 LDAC: -> MEM (read).
  - 2 STAC: -> MEM (write).
  - 3 ADD: alu_oper=ADD(1), b_sel=0, ld_ac=1.
  - 4 SUB:
    - alu_oper=SUB(2), b_sel=0, ld_ac=1.
    - z_q <= alu_z at the end of the cycle.
  - 5 MVACR: alu_oper=PASSATOC(7), ld_r=1.
  - 6 MVRAC: alu_oper=PASSBTOC(8), b_sel=0, ld_ac=1.
  - 7 JUMP: alu_oper=PASSBTOC, b_sel=2, ld_pc=1.
  - 8 JMPZ: as JUMP only if z_q=1; otherwise no strobes.
  - 9 JMPNZ: as JUMP only if z_q=0; otherwise no strobes.
  - 10 INAC: alu_oper=INCAC(9), ld_ac=1.
  - 11 DEAC: alu_oper=DECAC(10), ld_ac=1.
  - 12 LSHFT1: alu_oper=3, ld_ac=1.
  - 13 RSHFT4: alu_oper=6, ld_ac=1.
  - 14 CLAC: alu_oper=RESET(11), ld_ac=1.
  - 15 HALT: never reaches EXEC.
- MEM:
  - addr_sel=1; mem_rd=1 for LDAC, mem_wr=1 for STAC.
  - STAC: alu_oper=PASSATOC, so AC is driven on the C bus as write data.
  - Hold while mem_ready=0.
  - mem_ready=1 on LDAC: alu_oper=PASSBTOC, b_sel=1, ld_ac=1 in the same cycle.
  - mem_ready=1 (either opcode) -> FETCH.
- HALT: all strobes 0, halted=1; exit only by reset.
- Idle defaults: alu_oper=0 whenever not specified above, so the ALU takes its default path and outputs 0.
- mem_ready outside FETCH/MEM is ignored.
- z_q changes only in the SUB EXEC cycle.
- mem_rd and mem_wr are never asserted together.
- Latency with zero-wait memory:
  - ALU and jump instructions: 3 cycles (FETCH, DECODE, EXEC).
  - LDAC/STAC: 4 cycles.
  - Each wait cycle adds 1.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU operation codes (ADD=1 … RESET=11), also used by the ALU;
  - opcode constants 0–15;
  - the b_sel encodings;
  - the state encoding.
- No sub-module: a single FSM with one combinational output decoder.

Test Plan:
- Reset and start:
  - Hold rst_n=0 with run=1, then release.
  - Required: START for 1 cycle with all outputs 0, then mem_rd=1 in FETCH.
  - Assert rst_n=0 mid-FETCH: mem_rd=0 asynchronously.
- Zero-wait ADD:
  - Drive opcode=3 with mem_ready=1 in FETCH.
  - Required: ld_ir=inc_pc=1 in cycle 1, DECODE in cycle 2, then alu_oper=1, b_sel=0, ld_ac=1 in cycle 3, FETCH in cycle 4.
- SUB then branch:
  - Run SUB with alu_z=1, then JMPZ.
  - Required: z_q=1 after the SUB EXEC; JMPZ gives ld_pc=1, b_sel=2, alu_oper=8.
  - Repeat with alu_z=0: no ld_pc on JMPZ; JMPNZ gives ld_pc=1.
- LDAC with 3 wait cycles:
  - Required: mem_rd=1, addr_sel=1 held for 4 MEM cycles.
  - On the mem_ready cycle: b_sel=1, alu_oper=8, ld_ac=1, then FETCH.
- STAC with 2 wait cycles:
  - Required: mem_wr=1, alu_oper=7 held through MEM; mem_rd stays 0 throughout.
- HALT:
  - Drive opcode=15.
  - Required: DECODE goes to HALT, halted=1, and all strobes stay 0 for 100 cycles regardless of mem_ready and run.
  - Only rst_n recovers to START.
